// File: rtl/datapath_regalu_if.sv
// Per-cycle control bundle from the sequencing FSM to the execution datapath.
// master drives the control word, slave (the datapath) consumes it.
interface datapath_regalu_if;
   logic [15:0] immediate;
   logic        buff_en;
   logic [15:0] enable;
   logic [4:0]  control1;
   logic [4:0]  control2;
   logic        imm_control;
   logic [7:0]  opcode;

   modport master (
      output immediate, buff_en, enable, control1, control2, imm_control, opcode
   );
   modport slave (
      input immediate, buff_en, enable, control1, control2, imm_control, opcode
   );
endinterface

// File: rtl/datapath_regalu.sv
// Execution datapath: 16x16 register file, operand muxes, 16-bit ALU,
// registered {C,F,L,Z,N} flags and a commit-gated result bus.
module datapath_regalu (
   input  logic               clk,
   input  logic               reset,
   datapath_regalu_if.slave   ctl,
   input  logic [3:0]         dbg_sel,
   output logic [15:0]        bus,
   output logic [4:0]         flags,
   output logic [15:0]        dbg_data
);
   localparam int NREG = 16;
   localparam int W    = 16;

   localparam logic [7:0] OP_AND = 8'h01;
   localparam logic [7:0] OP_OR  = 8'h02;
   localparam logic [7:0] OP_XOR = 8'h03;
   localparam logic [7:0] OP_LSH = 8'h04;
   localparam logic [7:0] OP_ADD = 8'h05;
   localparam logic [7:0] OP_SUB = 8'h09;
   localparam logic [7:0] OP_CMP = 8'h0B;
   localparam logic [7:0] OP_MOV = 8'h0D;

   logic [W-1:0] regs [NREG];
   logic [W-1:0] op_a, op_b, result;
   logic [W:0]   sum, diff;
   logic         wr;
   logic [4:0]   next_flags;

   // Select codes 1..16 map to R0..R15; 16 wraps to index 15 via the 4-bit subtract.
   always_comb begin
      op_a = '0;
      op_b = '0;
      if (ctl.control1 != 5'd0 && ctl.control1 <= 5'd16)
         op_a = regs[ctl.control1[3:0] - 4'd1];
      if (ctl.imm_control)
         op_b = ctl.immediate;
      else if (ctl.control2 != 5'd0 && ctl.control2 <= 5'd16)
         op_b = regs[ctl.control2[3:0] - 4'd1];
   end

   assign sum  = {1'b0, op_a} + {1'b0, op_b};
   assign diff = {1'b0, op_a} - {1'b0, op_b};

   // next_flags bit order: [4]=C [3]=F [2]=L [1]=Z [0]=N
   always_comb begin
      result     = '0;
      wr         = 1'b0;
      next_flags = flags;
      case (ctl.opcode)
         OP_ADD: begin
            result        = sum[W-1:0];
            wr            = 1'b1;
            next_flags[4] = sum[W];
            next_flags[3] = (op_a[W-1] == op_b[W-1]) && (result[W-1] != op_a[W-1]);
         end
         OP_SUB: begin
            result        = diff[W-1:0];
            wr            = 1'b1;
            next_flags[4] = diff[W];
            next_flags[3] = (op_a[W-1] != op_b[W-1]) && (result[W-1] != op_a[W-1]);
         end
         OP_AND: begin result = op_a & op_b;      wr = 1'b1; end
         OP_OR:  begin result = op_a | op_b;      wr = 1'b1; end
         OP_XOR: begin result = op_a ^ op_b;      wr = 1'b1; end
         OP_MOV: begin result = op_b;             wr = 1'b1; end
         OP_LSH: begin result = op_a << op_b[3:0]; wr = 1'b1; end
         OP_CMP: begin
            next_flags[2] = op_a < op_b;
            next_flags[1] = op_a == op_b;
            next_flags[0] = $signed(op_a) < $signed(op_b);
         end
         default: ;
      endcase
      if (wr) begin
         next_flags[1] = result == '0;
         next_flags[0] = result[W-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NREG; k++) regs[k] <= '0;
         flags <= '0;
      end else if (ctl.buff_en) begin
         flags <= next_flags;
         if (wr)
            for (int k = 0; k < NREG; k++)
               if (ctl.enable[k]) regs[k] <= result;
      end
   end

   assign bus      = ctl.buff_en ? result : '0;
   assign dbg_data = regs[dbg_sel];
endmodule

// File: tb/tb_datapath_regalu.sv
// Directed bench for datapath_regalu: reset, decrement chain, flags, CMP,
// select boundaries, NOP and asynchronous reset during a pending write.
module tb_datapath_regalu;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  dbg_sel;
   logic [15:0] bus;
   logic [4:0]  flags;
   logic [15:0] dbg_data;
   int          checks = 0;
   int          fails  = 0;

   datapath_regalu_if ctl ();

   datapath_regalu dut (
      .clk      (clk),
      .reset    (reset),
      .ctl      (ctl.slave),
      .dbg_sel  (dbg_sel),
      .bus      (bus),
      .flags    (flags),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int idx, input logic [15:0] exp, input string tag);
      dbg_sel = idx[3:0];
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic chk_flags(input logic [4:0] exp, input string tag);
      chk(tag, {11'd0, flags}, {11'd0, exp});
   endtask

   // Drive one control word, check the combinational bus, then commit on the edge.
   task automatic run(input logic [7:0] op, input logic [4:0] c1, input logic [4:0] c2,
                      input logic ic, input logic [15:0] imm, input logic [15:0] en,
                      input logic [15:0] exp_bus, input string tag);
      ctl.opcode      = op;
      ctl.control1    = c1;
      ctl.control2    = c2;
      ctl.imm_control = ic;
      ctl.immediate   = imm;
      ctl.enable      = en;
      ctl.buff_en     = 1'b1;
      #1;
      chk(tag, bus, exp_bus);
      @(posedge clk);
      #1;
      ctl.buff_en = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      dbg_sel         = 4'd0;
      ctl.buff_en     = 1'b0;
      ctl.opcode      = 8'h00;
      ctl.control1    = 5'd0;
      ctl.control2    = 5'd0;
      ctl.imm_control = 1'b0;
      ctl.immediate   = 16'h0000;
      ctl.enable      = 16'h0000;

      for (int i = 0; i < 4; i++) begin
         ctl.opcode      = 8'($urandom_range(0, 255));
         ctl.control1    = 5'($urandom_range(0, 31));
         ctl.control2    = 5'($urandom_range(0, 31));
         ctl.imm_control = 1'($urandom_range(0, 1));
         ctl.immediate   = 16'($urandom_range(0, 65535));
         ctl.enable      = 16'($urandom_range(0, 65535));
         @(posedge clk);
         #1;
         chk("reset_bus", bus, 16'h0000);
      end
      for (int r = 0; r < 16; r++) rd(r, 16'h0000, "reset_reg");
      chk_flags(5'b00000, "reset_flags");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      run(8'h05, 5'd1, 5'd0, 1'b1, 16'd10, 16'h0002, 16'd10, "chain_r1");
      run(8'h09, 5'd2, 5'd0, 1'b1, 16'd1,  16'h0004, 16'd9,  "chain_r2");
      run(8'h09, 5'd3, 5'd0, 1'b1, 16'd1,  16'h0008, 16'd8,  "chain_r3");
      run(8'h09, 5'd4, 5'd0, 1'b1, 16'd1,  16'h0010, 16'd7,  "chain_r4");
      run(8'h09, 5'd5, 5'd0, 1'b1, 16'd1,  16'h0020, 16'd6,  "chain_r5");
      rd(1, 16'd10, "chain_rd1");
      rd(2, 16'd9,  "chain_rd2");
      rd(3, 16'd8,  "chain_rd3");
      rd(4, 16'd7,  "chain_rd4");
      rd(5, 16'd6,  "chain_rd5");
      chk_flags(5'b00000, "chain_flags");

      run(8'h0D, 5'd0, 5'd0, 1'b1, 16'hFFFF, 16'h0040, 16'hFFFF, "mov_ffff");
      chk_flags(5'b00001, "mov_ffff_flags");
      run(8'h05, 5'd7, 5'd0, 1'b1, 16'h0001, 16'h0080, 16'h0000, "add_carry");
      rd(7, 16'h0000, "add_carry_rd");
      chk_flags(5'b10010, "add_carry_flags");

      run(8'h0D, 5'd0, 5'd0, 1'b1, 16'h7FFF, 16'h0040, 16'h7FFF, "mov_7fff");
      chk_flags(5'b10000, "mov_7fff_flags");
      run(8'h05, 5'd7, 5'd0, 1'b1, 16'h0001, 16'h0080, 16'h8000, "add_ovf");
      chk_flags(5'b01001, "add_ovf_flags");

      run(8'h0D, 5'd0, 5'd0, 1'b1, 16'h0003, 16'h0040, 16'h0003, "mov_3");
      run(8'h09, 5'd7, 5'd0, 1'b1, 16'h0005, 16'h0080, 16'hFFFE, "sub_borrow");
      rd(7, 16'hFFFE, "sub_borrow_rd");
      chk_flags(5'b10001, "sub_borrow_flags");

      run(8'h0D, 5'd0, 5'd0, 1'b1, 16'h8000, 16'h0002, 16'h8000, "mov_r1");
      run(8'h0D, 5'd0, 5'd0, 1'b1, 16'h0001, 16'h0004, 16'h0001, "mov_r2");
      chk_flags(5'b10000, "mov_r2_flags");
      ctl.opcode = 8'h0B; ctl.control1 = 5'd2; ctl.control2 = 5'd3;
      ctl.imm_control = 1'b0; ctl.enable = 16'hFFFF; ctl.buff_en = 1'b1;
      @(posedge clk);
      #1;
      ctl.buff_en = 1'b0;
      chk_flags(5'b10001, "cmp_flags");
      rd(1, 16'h8000, "cmp_r1");
      rd(2, 16'h0001, "cmp_r2");
      rd(7, 16'hFFFE, "cmp_r7");
      rd(0, 16'h0000, "cmp_r0");

      run(8'h0D, 5'd0, 5'd0, 1'b1, 16'h0100, 16'h0001, 16'h0100, "mov_r0");
      run(8'h05, 5'd0,  5'd0, 1'b1, 16'h0011, 16'h0000, 16'h0011, "sel_c1_0");
      run(8'h05, 5'd20, 5'd0, 1'b1, 16'h0011, 16'h0000, 16'h0011, "sel_c1_20");
      chk_flags(5'b00000, "sel_flags");
      run(8'h0D, 5'd0, 5'd0,  1'b1, 16'hABCD, 16'h8000, 16'hABCD, "mov_r15");
      run(8'h0D, 5'd0, 5'd16, 1'b0, 16'h0000, 16'h0100, 16'hABCD, "sel_c2_16");
      rd(8, 16'hABCD, "sel_c2_16_rd");
      run(8'h0D, 5'd0, 5'd17, 1'b0, 16'h1111, 16'h0000, 16'h0000, "sel_c2_17");
      chk_flags(5'b00010, "sel_c2_17_flags");

      run(8'h01, 5'd16, 5'd0, 1'b1, 16'h0FF0, 16'h0000, 16'h0BC0, "and");
      run(8'h02, 5'd16, 5'd0, 1'b1, 16'h0FF0, 16'h0000, 16'hAFFD, "or");
      run(8'h03, 5'd16, 5'd0, 1'b1, 16'h0FF0, 16'h0000, 16'hA43D, "xor");
      run(8'h04, 5'd16, 5'd0, 1'b1, 16'h0014, 16'h0000, 16'hBCD0, "lsh");
      chk_flags(5'b00001, "lsh_flags");

      run(8'hFF, 5'd16, 5'd2, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, "nop_bus");
      chk_flags(5'b00001, "nop_flags");
      rd(1,  16'h8000, "nop_r1");
      rd(15, 16'hABCD, "nop_r15");

      run(8'h0D, 5'd0, 5'd0, 1'b1, 16'h1234, 16'h0008, 16'h1234, "mov_r3");
      rd(3, 16'h1234, "mov_r3_rd");
      ctl.opcode = 8'h0D; ctl.imm_control = 1'b1; ctl.immediate = 16'h5678;
      ctl.enable = 16'h0008; ctl.buff_en = 1'b1;
      dbg_sel = 4'd3;
      #2;
      reset = 1'b1;
      #1;
      chk("areset_imm", dbg_data, 16'h0000);
      @(posedge clk);
      #1;
      chk("areset_edge", dbg_data, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      ctl.buff_en = 1'b0;
      @(posedge clk);
      #1;
      chk("areset_after", dbg_data, 16'h0000);
      chk_flags(5'b00000, "areset_flags");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/datapath_regalu.md
# datapath_regalu

Execution datapath consuming the per-cycle control bundle produced by the sequencing FSM: `immediate`, `buff_en`, `enable`, `control1`, `control2`, `imm_control` and `opcode`. It holds a 16×16-bit register file, two operand-select muxes, an immediate mux, a 16-bit ALU, a registered flag word and a gated result bus. One control word executes per cycle; the result is written back on the next rising clock edge.

## Interface
- `NREG`, 16, number of general registers (R0..R15); fixed, one bit per register in `enable`
- `W`, 16, data width
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-high; clears registers and flags
- `immediate` in 16: immediate operand
- `buff_en` in 1: result-commit enable; gates writeback, flag update and bus drive
- `enable` in 16: one-hot (or multi-hot) register write enable; bit k targets Rk
- `control1` in 5: A-operand select
- `control2` in 5: B-operand select
- `imm_control` in 1: 1 means B = `immediate`, overriding `control2`
- `opcode` in 8: ALU operation
- `dbg_sel` in 4: register index for debug readout
- `bus` out 16: ALU result when `buff_en`=1, else 16'h0000 (combinational)
- `flags` out 5: registered {C, F, L, Z, N}
- `dbg_data` out 16: R[`dbg_sel`] (combinational)

## Operation
- Operand select, for both `control1` and `control2`:
  - value k in 1..16 selects R[k-1]
  - value 0 and values 17..31 select 16'h0000
- B = `immediate` when `imm_control`=1.
- Opcodes; A, B unsigned 16-bit; result truncated to 16 bits:
  - 0x05 ADD: A+B
  - 0x09 SUB: A−B
  - 0x01 AND, 0x02 OR, 0x03 XOR
  - 0x0D MOV: B
  - 0x04 LSH: A << B[3:0]
  - 0x0B CMP: no result, flags only
- Any other opcode is a NOP: result 16'h0000, no writeback, flags unchanged.
- Writeback at posedge `clk` when `buff_en`=1 and the opcode is not CMP or NOP:
  - every Rk with `enable[k]`=1 loads the result
  - multiple bits set means all selected registers load the same value
- No writeback when `buff_en`=0, `enable`=0, or the op is CMP/NOP.
- Flag update, only at posedge with `buff_en`=1:
  - ADD: C = carry-out; F = signed overflow
  - SUB: C = borrow (A<B unsigned); F = signed overflow
  - CMP: L = A<B unsigned; N = A<B signed; Z = (A==B). C and F are unchanged.
  - ADD/SUB/AND/OR/XOR/MOV/LSH: Z = (result==0), N = result[15]. L is unchanged.
  - Flags not listed for an op hold their value.
- Read-during-write: operands read the pre-edge register value. There is no bypass; the new value is visible the cycle after the edge.
- Source equals destination (e.g. R1 = R1 − 1) is legal; it uses the old value.

## Timing
- Reset values:
  - all R0..R15 = 16'h0000
  - `flags` = 5'b00000
  - `bus` = 0 (since `buff_en`=0 in the upstream reset state)
  - `dbg_data` = 16'h0000
- Reset is asynchronous. Asserting it mid-operation clears state immediately, independent of `clk`. A write pending in that cycle is discarded. While `reset`=1 no register or flag updates occur.
- `bus`: zero-latency combinational function of the inputs and current register state.
- Writeback latency: 1 edge. A control word applied in cycle n produces updated registers and flags from cycle n+1.
- Upstream control is stable before the posedge, which sets the internal setup budget to a full cycle. There is no handshake; every cycle with `buff_en`=1 commits.
- Back-to-back dependent ops (R2←R1−1 in cycle n+1 after R1←10 in cycle n) see the committed value; no stall is needed.

## Test plan
- Reset then idle: assert `reset`, apply random control with `buff_en`=0 -> all `dbg_data` reads 0, `flags`=0, `bus`=0.
- Decrement chain, one word per cycle, `imm_control`=1 throughout:
  - R1 = R0 + 10: `control1`=1, imm=10, op 0x05, `enable`=0x0002
  - then R2..R5 each = previous − 1: op 0x09, imm=1, `control1`=2..5, `enable`=0x0004..0x0020
  - -> R1..R5 = 10, 9, 8, 7, 6
  - -> `bus` shows 10, 9, 8, 7, 6 in the respective cycles
- Arithmetic flags:
  - ADD 0xFFFF+1 -> result 0, C=1, Z=1
  - ADD 0x7FFF+1 -> F=1, N=1
  - SUB 3−5 -> result 0xFFFE, C=1, N=1
- CMP with R1=0x8000, R2=1:
  - -> L=0, N=1 (signed less), Z=0
  - -> no register changes even with `enable`=0xFFFF
  - -> C and F unchanged
- Boundary selects:
  - `control1`=0 and `control1`=20 both give A=0
  - `control2`=16 selects R15
  - NOP opcode 0xFF with `buff_en`=1 -> registers and flags unchanged
- Async reset mid-write: load R3=0x1234, then assert `reset` between edges while a write to R3 is pending -> R3 reads 0 immediately and stays 0 after the next edge.
